t_pulse_gen: RTL and testbench
==============================

# t_pulse_gen

Programmable toggle-command generator that sits directly upstream of the T flip-flop and drives its `t` input. On a `start` request it issues `count` single-cycle toggle pulses, spaced `period` clock cycles apart. It then signals completion. It turns the flip-flop into a controllable N-toggle / divide-by-P output stage.

## Interface
- `CNT_W`, default 8: width of the `period`, `count` and `pulses_left` fields.

- `clk`  in  1  rising-edge clock, shared with the downstream T flip-flop.
- `rst`  in  1  asynchronous, active-high reset.
- `start`  in  1  request; sampled only in IDLE.
- `period`  in  CNT_W  cycles between pulses; sampled with `start`; 0 is treated as 1.
- `count`  in  CNT_W  number of pulses to issue; sampled with `start`.
- `abort`  in  1  cancels a run in progress.
- `t_out`  out  1  registered toggle command; connects to the flip-flop `t`.
- `busy`  out  1  high while a run is active.
- `done`  out  1  one-cycle completion pulse.
- `pulses_left`  out  CNT_W  pulses still to be issued in the current run.

## Operation
- Reset (async, `rst`=1) forces IDLE immediately. All outputs (`t_out`, `busy`, `done`, `pulses_left`) become 0. The internal timer becomes 0. Outputs stay 0 while `rst` is held.
- FSM has three states: IDLE, RUN, FIN.
- IDLE, `start`=1, `count`≠0:
  - Latch P = max(`period`,1) and N = `count`.
  - Load the timer with P−1 and set `pulses_left`=N.
  - Next state is RUN.
- IDLE, `start`=1, `count`=0:
  - Next state is FIN; no pulses are issued.
  - `busy` stays 0.
- RUN, each edge:
  - If the timer ≠ 0, decrement it.
  - If the timer = 0: assert `t_out` for the next cycle, decrement `pulses_left`, and reload the timer with P−1.
  - If that pulse brings `pulses_left` to 0, next state is FIN.
- FIN: `done`=1 for exactly one cycle, then IDLE.
- `t_out` is 0 in every cycle not selected above. With P=1 it stays high for N consecutive cycles.
- `start` in RUN or FIN is ignored. Inputs are not re-sampled mid-run.
- `abort`=1 in RUN:
  - Next edge: state IDLE, `t_out`=0, `busy`=0, `pulses_left`=0.
  - No `done` is generated.
  - `abort` has priority over a pulse due on the same edge.
- `abort` in IDLE or FIN has no effect.
- `start` and `abort` both high in IDLE: `start` wins, because `abort` is ignored in IDLE.
- Counter width: `pulses_left` and the timer are CNT_W bits wide and never wrap. Decrement only happens from a nonzero value.

## Timing
- Let E0 be the edge at which `start` is accepted.
- `busy` rises at E0. It falls at edge E0+N·P+1, the same edge at which `done` rises.
- Pulse k (k = 1..N):
  - `t_out` goes high at edge E0+k·P and is held for one cycle.
  - `pulses_left` becomes N−k at that same edge.
- `done` is high for the single cycle between edges E0+N·P+1 and E0+N·P+2.
- Earliest next `start` acceptance is edge E0+N·P+2.
- `count`=0 case: `done` is high for the cycle after E0; `busy` is never asserted.
- The downstream flip-flop samples `t_out` at the edge after it rises, so `q` toggles at edges E0+k·P+1.
- All outputs are registered; there are no combinational input-to-output paths.

## Test plan
- Reset: assert `rst` mid-cycle with `start`=1 → `t_out`, `busy`, `done` and `pulses_left` read 0 immediately. Deassert `rst`, then start P=2, N=1 → single pulse at E0+2.
- P=1, N=3 → `t_out` high for the 3 cycles after E0+1..E0+3. `pulses_left` reads 2, 1, 0. `done` is high after E0+4. A chained T flip-flop starting at q=0 ends at q=1.
- P=3, N=2 → pulses after E0+3 and E0+6 only. `done` after E0+7. `busy` is high from E0 until E0+7.
- `count`=0 with P=5 → no `t_out`, `busy` stays 0, `done` pulses once after E0+1.
- P=2, N=4: assert `start` with new values at E0+3 → ignored; exactly 4 pulses. Then assert `abort` coincident with the edge of pulse 2 in a second run → no pulse 2, `busy`=0, no `done`.
- P=4, N=5: assert `rst` asynchronously after pulse 2 → all outputs 0 at once. After release, the FSM is in IDLE and accepts a fresh `start`.

Source files
------------

// File: rtl/t_pulse_gen.sv
// Programmable toggle-command generator: on start, emits `count` single-cycle
// pulses on t_out spaced `period` cycles apart, then a one-cycle done strobe.
module t_pulse_gen #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [CNT_W-1:0] period,
  input  logic [CNT_W-1:0] count,
  input  logic             abort,
  output logic             t_out,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] pulses_left
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_FIN  = 2'd2;

  logic [1:0]       r_state;
  logic [CNT_W-1:0] r_timer;
  logic [CNT_W-1:0] r_period_m1;
  logic [CNT_W-1:0] r_pulses_left;
  logic             r_t_out;
  logic             r_busy;
  logic             r_done;

  // A period of 0 behaves as 1, so the reload value saturates at 0.
  logic [CNT_W-1:0] w_period_m1;
  assign w_period_m1 = (period == '0) ? '0 : (period - CNT_W'(1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state       <= S_IDLE;
      r_timer       <= '0;
      r_period_m1   <= '0;
      r_pulses_left <= '0;
      r_t_out       <= 1'b0;
      r_busy        <= 1'b0;
      r_done        <= 1'b0;
    end else begin
      r_t_out <= 1'b0;
      r_done  <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            if (count != '0) begin
              r_period_m1   <= w_period_m1;
              r_timer       <= w_period_m1;
              r_pulses_left <= count;
              r_busy        <= 1'b1;
              r_state       <= S_RUN;
            end else begin
              r_state <= S_FIN;
            end
          end
        end
        S_RUN: begin
          // Abort wins over a pulse that would fire on the same edge.
          if (abort) begin
            r_state       <= S_IDLE;
            r_busy        <= 1'b0;
            r_pulses_left <= '0;
            r_timer       <= '0;
          end else if (r_timer != '0) begin
            r_timer <= r_timer - CNT_W'(1);
          end else begin
            r_t_out <= 1'b1;
            r_timer <= r_period_m1;
            if (r_pulses_left != '0) begin
              r_pulses_left <= r_pulses_left - CNT_W'(1);
            end
            if (r_pulses_left <= CNT_W'(1)) begin
              r_state <= S_FIN;
            end
          end
        end
        S_FIN: begin
          r_done  <= 1'b1;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign t_out       = r_t_out;
  assign busy        = r_busy;
  assign done        = r_done;
  assign pulses_left = r_pulses_left;

endmodule

// File: tb/tb_t_pulse_gen.sv
// Scoreboard bench for t_pulse_gen: expected per-cycle output vectors are derived
// from the edge-timing formulas and queued at start, then popped each cycle.
module tb_t_pulse_gen;
  localparam int W = 8;
  typedef logic [W+2:0] vec_t;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         start = 1'b0;
  logic [W-1:0] period = '0;
  logic [W-1:0] count = '0;
  logic         abort = 1'b0;
  logic         t_out, busy, done;
  logic [W-1:0] pulses_left;
  logic         q;

  int   n_checks = 0;
  int   n_fail = 0;
  vec_t sb[$];
  vec_t obs, exp_v;

  always #5 clk = ~clk;

  t_pulse_gen #(.CNT_W(W)) dut (
    .clk(clk), .rst(rst), .start(start), .period(period), .count(count),
    .abort(abort), .t_out(t_out), .busy(busy), .done(done),
    .pulses_left(pulses_left)
  );

  // Downstream T flip-flop fed by t_out.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) q <= 1'b0;
    else if (t_out) q <= ~q;
  end

  assign obs = {t_out, busy, done, pulses_left};

  // Expected {t_out,busy,done,pulses_left} after edge E0+j; zeros from j >= cut.
  function automatic void push_run(int p_in, int n, int len, int cut);
    int p = (p_in == 0) ? 1 : p_in;
    for (int j = 0; j < len; j++) begin
      logic t, b, d;
      logic [W-1:0] pl;
      t  = (j > 0) && (j % p == 0) && (j / p <= n);
      b  = (n != 0) && (j <= n * p);
      d  = (j == n * p + 1);
      pl = (j <= n * p) ? W'(n - j / p) : '0;
      if (j >= cut) sb.push_back('0);
      else sb.push_back({t, b, d, pl});
    end
  endfunction

  task automatic do_start(int p, int n);
    @(negedge clk);
    start = 1'b1; period = W'(p); count = W'(n);
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic test_reset();
    int j = 0;
    start = 1'b1; period = 8'd2; count = 8'd1;
    #3 rst = 1'b1;
    #1;
    n_checks++;
    if (obs !== '0) begin n_fail++; $display("FAIL reset_async got %h want 0", obs); end
    @(posedge clk); #1;
    n_checks++;
    if (obs !== '0) begin n_fail++; $display("FAIL reset_hold got %h want 0", obs); end
    @(negedge clk); rst = 1'b0; start = 1'b0;
    push_run(2, 1, 5, 99);
    do_start(2, 1);
    while (sb.size() > 0) begin
      exp_v = sb.pop_front(); n_checks++;
      if (obs !== exp_v) begin n_fail++; $display("FAIL reset_p2n1 cyc%0d got %h want %h", j, obs, exp_v); end
      j++;
      if (sb.size() > 0) begin @(posedge clk); #1; end
    end
  endtask

  task automatic test_p1n3();
    int   j = 0;
    logic q0 = q;
    push_run(1, 3, 6, 99);
    do_start(1, 3);
    while (sb.size() > 0) begin
      exp_v = sb.pop_front(); n_checks++;
      if (obs !== exp_v) begin n_fail++; $display("FAIL p1n3 cyc%0d got %h want %h", j, obs, exp_v); end
      j++;
      if (sb.size() > 0) begin @(posedge clk); #1; end
    end
    n_checks++;
    if (q !== ~q0) begin n_fail++; $display("FAIL p1n3_tff got %b want %b", q, ~q0); end
  endtask

  task automatic test_p3n2();
    int j = 0;
    push_run(3, 2, 9, 99);
    do_start(3, 2);
    while (sb.size() > 0) begin
      exp_v = sb.pop_front(); n_checks++;
      if (obs !== exp_v) begin n_fail++; $display("FAIL p3n2 cyc%0d got %h want %h", j, obs, exp_v); end
      j++;
      if (sb.size() > 0) begin @(posedge clk); #1; end
    end
  endtask

  task automatic test_count0();
    int j = 0;
    push_run(5, 0, 4, 99);
    do_start(5, 0);
    while (sb.size() > 0) begin
      exp_v = sb.pop_front(); n_checks++;
      if (obs !== exp_v) begin n_fail++; $display("FAIL count0 cyc%0d got %h want %h", j, obs, exp_v); end
      j++;
      if (sb.size() > 0) begin @(posedge clk); #1; end
    end
  endtask

  task automatic test_start_ignored();
    int j = 0;
    int pulses = 0;
    push_run(2, 4, 11, 99);
    do_start(2, 4);
    while (sb.size() > 0) begin
      exp_v = sb.pop_front(); n_checks++;
      if (obs !== exp_v) begin n_fail++; $display("FAIL start_ign cyc%0d got %h want %h", j, obs, exp_v); end
      if (t_out === 1'b1) pulses++;
      if (j == 2) begin start = 1'b1; period = 8'd1; count = 8'd7; end
      if (j == 3) start = 1'b0;
      j++;
      if (sb.size() > 0) begin @(posedge clk); #1; end
    end
    n_checks++;
    if (pulses != 4) begin n_fail++; $display("FAIL start_ign_pulses got %0d want 4", pulses); end
  endtask

  task automatic test_abort();
    int j = 0;
    int dones = 0;
    push_run(2, 4, 10, 4);
    do_start(2, 4);
    while (sb.size() > 0) begin
      exp_v = sb.pop_front(); n_checks++;
      if (obs !== exp_v) begin n_fail++; $display("FAIL abort cyc%0d got %h want %h", j, obs, exp_v); end
      if (done === 1'b1) dones++;
      if (j == 3) abort = 1'b1;
      if (j == 4) abort = 1'b0;
      j++;
      if (sb.size() > 0) begin @(posedge clk); #1; end
    end
    n_checks++;
    if (dones != 0) begin n_fail++; $display("FAIL abort_done got %0d want 0", dones); end
  endtask

  task automatic test_async_rst();
    int j = 0;
    push_run(4, 5, 23, 99);
    do_start(4, 5);
    while (sb.size() > 0) begin
      exp_v = sb.pop_front(); n_checks++;
      if (obs !== exp_v) begin n_fail++; $display("FAIL arst_run cyc%0d got %h want %h", j, obs, exp_v); end
      if (j == 8) sb.delete();
      j++;
      if (sb.size() > 0) begin @(posedge clk); #1; end
    end
    #2 rst = 1'b1;
    #1;
    n_checks++;
    if (obs !== '0) begin n_fail++; $display("FAIL arst_now got %h want 0", obs); end
    @(posedge clk); #1;
    n_checks++;
    if (obs !== '0) begin n_fail++; $display("FAIL arst_hold got %h want 0", obs); end
    @(negedge clk); rst = 1'b0;
    j = 0;
    push_run(1, 2, 5, 99);
    do_start(1, 2);
    while (sb.size() > 0) begin
      exp_v = sb.pop_front(); n_checks++;
      if (obs !== exp_v) begin n_fail++; $display("FAIL arst_restart cyc%0d got %h want %h", j, obs, exp_v); end
      j++;
      if (sb.size() > 0) begin @(posedge clk); #1; end
    end
  endtask

  initial begin
    test_reset();
    test_p1n3();
    test_p3n2();
    test_count0();
    test_start_ignored();
    test_abort();
    test_async_rst();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
